// File: rtl/sine_sample_src.sv
// Streaming DDS sine source: phase accumulator feeding a quarter-wave ROM,
// with a globally stalled pipeline and valid/ready output handshake.
module sine_sample_src #(
  parameter int DATA_W    = 33,
  parameter int PHASE_W   = 24,
  parameter int LUT_AW    = 8,
  parameter int AMPLITUDE = 32767
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     sync_clr,
  input  logic [PHASE_W-1:0]       phase_inc,
  input  logic                     load_inc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic [31:0]              sample_cnt
);

  localparam int              LUT_N   = (1 << LUT_AW) + 1;
  localparam logic [LUT_AW:0] LUT_TOP = {1'b1, {LUT_AW{1'b0}}};

  // Elaboration-time sine via Taylor series, rounded to nearest and clamped.
  function automatic int lut_entry(input int k);
    real x;
    real term;
    real acc;
    int  v;
    x    = 1.5707963267948966 * real'(k) / real'(1 << LUT_AW);
    term = x;
    acc  = x;
    for (int n = 1; n <= 10; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      acc  = acc + term;
    end
    v = $rtoi(real'(AMPLITUDE) * acc + 0.5);
    if (v > AMPLITUDE) v = AMPLITUDE;
    if (v < 0) v = 0;
    return v;
  endfunction

  logic [DATA_W-1:0] w_lut [0:LUT_N-1];

  for (genvar gi = 0; gi < LUT_N; gi++) begin : g_lut
    localparam int ENTRY = lut_entry(gi);
    assign w_lut[gi] = DATA_W'(ENTRY);
  end

  logic [PHASE_W-1:0] r_phase;
  logic [PHASE_W-1:0] r_inc;
  logic               r_v1;
  logic               r_v2;
  logic               r_v3;
  logic               r_v4;
  logic [LUT_AW+1:0]  r_ph1;
  logic [LUT_AW:0]    r_addr2;
  logic               r_neg2;
  logic [DATA_W-1:0]  r_mag3;
  logic               r_neg3;
  logic [DATA_W-1:0]  r_data;
  logic [31:0]        r_cnt;

  logic               w_adv;
  logic [1:0]         w_quad;
  logic [LUT_AW:0]    w_idx;
  logic [LUT_AW:0]    w_addr;

  // Everything advances together unless a presented sample is being refused.
  assign w_adv  = !(r_v4 && !out_ready);
  assign w_quad = r_ph1[LUT_AW+1:LUT_AW];
  assign w_idx  = {1'b0, r_ph1[LUT_AW-1:0]};
  assign w_addr = w_quad[0] ? (LUT_TOP - w_idx) : w_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inc <= '0;
    end else if (load_inc) begin
      r_inc <= phase_inc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_phase <= '0;
      r_v1    <= 1'b0;
      r_ph1   <= '0;
    end else if (sync_clr) begin
      r_phase <= '0;
      r_v1    <= 1'b0;
    end else if (w_adv) begin
      r_v1 <= enable;
      if (enable) begin
        r_ph1   <= r_phase[PHASE_W-1 -: LUT_AW+2];
        r_phase <= r_phase + r_inc;
      end
    end
  end

  // ROM read kept reset-free so it can map onto block memory.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_mag3 <= w_lut[r_addr2];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      r_v4    <= 1'b0;
      r_addr2 <= '0;
      r_neg2  <= 1'b0;
      r_neg3  <= 1'b0;
      r_data  <= '0;
    end else if (sync_clr) begin
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_v4   <= 1'b0;
      r_data <= '0;
    end else if (w_adv) begin
      r_v2    <= r_v1;
      r_addr2 <= w_addr;
      r_neg2  <= w_quad[1];
      r_v3    <= r_v2;
      r_neg3  <= r_neg2;
      r_v4    <= r_v3;
      if (r_v3) begin
        r_data <= r_neg3 ? -r_mag3 : r_mag3;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (sync_clr) begin
      r_cnt <= '0;
    end else if (r_v4 && out_ready) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  assign out_valid  = r_v4;
  assign out_data   = r_data;
  assign sample_cnt = r_cnt;

endmodule
